// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB control with ready-handshaked memories.
// Requests stay high until ready; a stalled request longer than TIMEOUT_CYCLES halts the core.
`timescale 1ns/1ps
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        inclk,
  input  logic        rstn,
  output logic        IM_R,
  output logic [31:0] o_IM_addr,
  input  logic        i_IM_ready,
  input  logic [31:0] i_IM_rdata,
  output logic        DM_CS,
  output logic        DM_R,
  output logic        DM_W,
  output logic [31:0] o_DM_addr,
  output logic [31:0] o_DM_wdata,
  input  logic        i_DM_ready,
  input  logic [31:0] i_DM_rdata,
  output logic [31:0] o_PC_out,
  output logic [31:0] o_ALU_out,
  output logic [2:0]  o_state,
  output logic        o_halt,
  output logic [1:0]  o_halt_cause
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] C_ILLEGAL = 2'd1;
  localparam logic [1:0] C_IM_TO   = 2'd2;
  localparam logic [1:0] C_DM_TO   = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, wait_q, wait_d;
  logic        halt_q, halt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic [31:0] imm_sext, imm_zext, pc_plus4, jtarget, btarget, alu_res;
  logic        is_r, is_jr, is_lw, is_sw, is_br, legal, taken, timed_out;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign tgt   = ir_q[25:0];

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign jtarget  = {pc_plus4[31:28], tgt, 2'b00};
  assign btarget  = pc_plus4 + {imm_sext[29:0], 2'b00};

  assign is_r  = (op == OP_R);
  assign is_jr = is_r && (funct == FN_JR);
  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  assign is_br = (op == OP_BEQ) || (op == OP_BNE);
  assign taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  // A zero limit disables the watchdog entirely.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_CYCLES);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_JR: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a_q + imm_sext;
    case (op)
      OP_R: begin
        case (funct)
          FN_SUBU: alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
          FN_SLL:  alu_res = b_q << shamt;
          default: alu_res = a_q + b_q;
        endcase
      end
      OP_ANDI:        alu_res = a_q & imm_zext;
      OP_ORI:         alu_res = a_q | imm_zext;
      OP_LUI:         alu_res = {imm, 16'h0000};
      OP_BEQ, OP_BNE: alu_res = a_q - b_q;
      default:        alu_res = a_q + imm_sext;
    endcase
  end

  // wait_d defaults to zero, so any state change clears the stall counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    wait_d  = '0;
    halt_d  = halt_q;
    cause_d = cause_q;
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    case (state_q)
      S_FETCH: begin
        if (i_IM_ready) begin
          ir_d    = i_IM_rdata;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          cause_d = C_IM_TO;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DECODE: begin
        a_d = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        b_d = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        if (!legal) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          cause_d = C_ILLEGAL;
        end else if (op == OP_J) begin
          pc_d    = jtarget;
          state_d = S_FETCH;
        end else if (op == OP_JAL) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_br) begin
          pc_d    = taken ? btarget : pc_plus4;
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_d    = a_q;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (i_DM_ready) begin
          if (is_lw) begin
            mdr_d   = i_DM_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end
        end else if (timed_out) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          cause_d = C_DM_TO;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        if (op == OP_JAL) begin
          rf_wa = 5'd31;
          rf_wd = pc_plus4;
          pc_d  = jtarget;
        end else if (is_lw) begin
          rf_wa = rt;
          rf_wd = mdr_q;
        end else begin
          rf_wa = is_r ? rd : rt;
          rf_wd = alu_q;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge inclk) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      wait_q  <= '0;
      halt_q  <= 1'b0;
      cause_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      wait_q  <= wait_d;
      halt_q  <= halt_d;
      cause_q <= cause_d;
      if (rf_we && (rf_wa != 5'd0)) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign IM_R         = rstn && (state_q == S_FETCH);
  assign DM_CS        = rstn && (state_q == S_MEM);
  assign DM_R         = DM_CS && is_lw;
  assign DM_W         = DM_CS && is_sw;
  assign o_IM_addr    = pc_q;
  assign o_DM_addr    = alu_q;
  assign o_DM_wdata   = b_q;
  assign o_PC_out     = pc_q;
  assign o_ALU_out    = alu_q;
  assign o_state      = state_q;
  assign o_halt       = halt_q;
  assign o_halt_cause = cause_q;

endmodule
